// File: rtl/tcm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tcm_pkg - shared constants and response-entry type for the TCM port-1 path.
// Rev 1.0
// ---------------------------------------------------------------------------
package tcm_pkg;

  localparam int TCM_WIN_MSB  = 31;
  localparam int TCM_WIN_LSB  = 17;
  localparam int TCM_WORD_LSB = 3;
  localparam int TCM_ID_W_MAX = 16;

  // id is sized for the widest supported tag; narrower tags use the low bits
  typedef struct packed {
    logic [63:0]             data;
    logic [TCM_ID_W_MAX-1:0] id;
    logic                    write;
    logic                    error;
  } tcm_resp_t;

endpackage
`default_nettype wire

// File: rtl/tcm_resp_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tcm_resp_fifo - synchronous response FIFO; head holds last popped entry when empty.
// Rev 1.0
// ---------------------------------------------------------------------------
module tcm_resp_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [WIDTH-1:0] last_q;
  logic             do_pop;

  assign do_pop = pop & (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        last_q <= mem[rd_ptr];
      end
      case ({push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = (count_q != '0) ? mem[rd_ptr] : last_q;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/tcm_mem_port_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tcm_mem_port_ctrl - valid/accept front end for the external port of the TCM RAM.
// Rev 1.0
// ---------------------------------------------------------------------------
module tcm_mem_port_ctrl
  import tcm_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int          RAM_ADDR_W = 14,
  parameter int          FIFO_DEPTH = 2,
  parameter int          ID_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  input  logic                  req_write_i,
  input  logic [31:0]           req_addr_i,
  input  logic [63:0]           req_data_i,
  input  logic [7:0]            req_strb_i,
  input  logic [ID_W-1:0]       req_id_i,
  output logic                  req_accept_o,
  output logic                  resp_valid_o,
  output logic [63:0]           resp_data_o,
  output logic [ID_W-1:0]       resp_id_o,
  output logic                  resp_write_o,
  output logic                  resp_error_o,
  input  logic                  resp_accept_i,
  output logic [RAM_ADDR_W-1:0] ram_addr_o,
  output logic [63:0]           ram_data_o,
  output logic [7:0]            ram_wr_o,
  input  logic [63:0]           ram_data_i
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic            fire;
  logic            in_range;
  logic            inflight_q;
  logic [ID_W-1:0] id_q;
  logic            write_q;
  logic            error_q;
  tcm_resp_t       push_entry;
  tcm_resp_t       head;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             unused_bits;

  assign fire     = req_valid_i & req_accept_o;
  assign in_range = (req_addr_i[TCM_WIN_MSB:TCM_WIN_LSB] == BASE_ADDR[TCM_WIN_MSB:TCM_WIN_LSB]);

  assign ram_addr_o = req_addr_i[TCM_WORD_LSB +: RAM_ADDR_W];
  assign ram_data_o = req_data_i;
  assign ram_wr_o   = (fire & req_write_i & in_range) ? req_strb_i : 8'h00;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inflight_q <= 1'b0;
      id_q       <= '0;
      write_q    <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      inflight_q <= fire;
      if (fire) begin
        id_q    <= req_id_i;
        write_q <= req_write_i;
        error_q <= ~in_range;
      end
    end
  end

  // RAM read data is only meaningful for an in-range read issued last cycle
  always_comb begin
    push_entry               = '0;
    push_entry.id[ID_W-1:0]  = id_q;
    push_entry.write         = write_q;
    push_entry.error         = error_q;
    push_entry.data          = (write_q | error_q) ? 64'h0 : ram_data_i;
  end

  tcm_resp_fifo #(
    .WIDTH ($bits(tcm_resp_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (inflight_q),
    .push_data (push_entry),
    .pop       (resp_valid_o & resp_accept_i),
    .head      (head),
    .count     (count)
  );

  // Reserve a FIFO slot for every request still in the RAM pipeline
  assign occupancy    = {1'b0, count} + {{CNT_W{1'b0}}, inflight_q};
  assign req_accept_o = ~rst_i & (occupancy < (CNT_W + 1)'(FIFO_DEPTH));

  assign resp_valid_o = (count != '0);
  assign resp_data_o  = head.data;
  assign resp_id_o    = head.id[ID_W-1:0];
  assign resp_write_o = head.write;
  assign resp_error_o = head.error;

  assign unused_bits = ^{req_addr_i[TCM_WORD_LSB-1:0], head.id};

endmodule
`default_nettype wire
